// File: rtl/bsg_fsb_pkg.sv
// Shared FSB constants, arbiter state encoding and pointer-wrap helper.
package bsg_fsb_pkg;

    localparam int unsigned fsb_id_width_gp  = 4;
    localparam int unsigned fsb_max_nodes_gp = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    typedef enum logic [0:0] {
        IDLE = ST_IDLE,
        HOLD = ST_HOLD
    } arb_state_e;

    // Explicit compare so non-power-of-2 master counts wrap correctly.
    function automatic logic [fsb_id_width_gp-1:0] wrap_inc(
        input logic [fsb_id_width_gp-1:0] id,
        input int unsigned                n
    );
        return (32'(id) == n - 1) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/bsg_fsb_rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr_i, wrapping.
module bsg_fsb_rr_pick
    import bsg_fsb_pkg::*;
#(
    parameter int unsigned num_p = 4
) (
    input  logic [num_p-1:0]           req_i,
    input  logic [fsb_id_width_gp-1:0] ptr_i,
    output logic [num_p-1:0]           grant_o,
    output logic [fsb_id_width_gp-1:0] id_o,
    output logic                       v_o
);

    int unsigned idx;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        v_o     = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < num_p; i++) begin
            idx = 32'(ptr_i) + i;
            if (idx >= num_p) idx = idx - num_p;
            for (int unsigned j = 0; j < num_p; j++) begin
                if (!v_o && (idx == j) && req_i[j]) begin
                    v_o        = 1'b1;
                    grant_o[j] = 1'b1;
                    id_o       = fsb_id_width_gp'(j);
                end
            end
        end
    end

endmodule

// File: rtl/bsg_fsb_master_arbiter.sv
// Round-robin/burst arbiter sharing one FSB output channel among test-node masters.
// Optional starvation watchdog: define BSG_FSB_MASTER_ARBITER_WATCHDOG_EN.
module bsg_fsb_master_arbiter
    import bsg_fsb_pkg::*;
#(
    parameter int unsigned num_masters_p     = 4,
    parameter int unsigned ring_width_p      = 80,
    parameter int unsigned burst_p           = 1,
    parameter int unsigned watchdog_cycles_p = 1024
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  en_i,
    input  logic [num_masters_p-1:0]              v_i,
    input  logic [num_masters_p*ring_width_p-1:0] data_i,
    output logic [num_masters_p-1:0]              yumi_o,
    input  logic [num_masters_p-1:0]              done_i,
    output logic                                  v_o,
    output logic [ring_width_p-1:0]               data_o,
    input  logic                                  yumi_i,
    output logic [fsb_id_width_gp-1:0]            grant_id_o,
    output logic                                  all_done_o,
    output logic                                  error_o
);

    arb_state_e                  state_q, state_d;
    logic [fsb_id_width_gp-1:0]  owner_q, owner_d;
    logic [fsb_id_width_gp-1:0]  ptr_q, ptr_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        v_q, v_d;
    logic [ring_width_p-1:0]     data_q, data_d;
    logic [fsb_id_width_gp-1:0]  gid_q, gid_d;
    logic [num_masters_p-1:0]    done_q, done_d;
    logic                        all_done_q, all_done_d;

    logic [num_masters_p-1:0]    rr_grant, owner_oh;
    logic [fsb_id_width_gp-1:0]  rr_id, sel_id;
    logic                        rr_v, owner_v, hold_active, space, accept;
    logic [ring_width_p-1:0]     sel_data;

    bsg_fsb_rr_pick #(.num_p(num_masters_p)) u_pick (
        .req_i   (v_i),
        .ptr_i   (ptr_q),
        .grant_o (rr_grant),
        .id_o    (rr_id),
        .v_o     (rr_v)
    );

    always_comb begin
        owner_oh = '0;
        owner_v  = 1'b0;
        sel_data = '0;
        for (int unsigned k = 0; k < num_masters_p; k++) begin
            if (owner_q == fsb_id_width_gp'(k)) begin
                owner_oh[k] = 1'b1;
                owner_v     = v_i[k];
            end
        end
        hold_active = (state_q == HOLD) && owner_v;
        sel_id      = hold_active ? owner_q : rr_id;
        space       = ~v_q | yumi_i;
        accept      = ~reset_i & en_i & space & (hold_active | rr_v);
        yumi_o      = accept ? (hold_active ? owner_oh : rr_grant) : '0;
        for (int unsigned k = 0; k < num_masters_p; k++) begin
            if (sel_id == fsb_id_width_gp'(k)) sel_data = data_i[k*ring_width_p +: ring_width_p];
        end
    end

    // Pointer advances on entry to a burst, so a dropped owner hands over from owner+1 at once.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (en_i && space) begin
            if (hold_active) begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_d == 8'(burst_p)) state_d = IDLE;
            end else begin
                state_d = IDLE;
                if (accept) begin
                    ptr_d = wrap_inc(sel_id, num_masters_p);
                    if (burst_p > 1) begin
                        state_d = HOLD;
                        owner_d = sel_id;
                        cnt_d   = 8'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        v_d        = v_q;
        data_d     = data_q;
        gid_d      = gid_q;
        if (accept) begin
            v_d    = 1'b1;
            data_d = sel_data;
            gid_d  = sel_id;
        end else if (yumi_i) begin
            v_d    = 1'b0;
        end
        done_d     = done_q | done_i;
        all_done_d = &done_q;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            v_q        <= 1'b0;
            data_q     <= '0;
            gid_q      <= '0;
            done_q     <= '0;
            all_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            v_q        <= v_d;
            data_q     <= data_d;
            gid_q      <= gid_d;
            done_q     <= done_d;
            all_done_q <= all_done_d;
        end
    end

    assign v_o        = v_q;
    assign data_o     = data_q;
    assign grant_id_o = gid_q;
    assign all_done_o = all_done_q;

`ifdef BSG_FSB_MASTER_ARBITER_WATCHDOG_EN
    localparam logic [31:0] wd_limit_lp = 32'(watchdog_cycles_p);

    logic [31:0] wait_q [num_masters_p];
    logic [31:0] wait_d [num_masters_p];
    logic        err_q, err_d;

    // Counters saturate at the limit so the error fires once per starving master.
    always_comb begin
        wait_d = wait_q;
        err_d  = err_q;
        for (int unsigned k = 0; k < num_masters_p; k++) begin
            if (yumi_o[k]) begin
                wait_d[k] = '0;
            end else if (v_i[k] && en_i && (wait_q[k] != wd_limit_lp)) begin
                wait_d[k] = wait_q[k] + 32'd1;
                if (wait_d[k] == wd_limit_lp) err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wait_q <= '{default: '0};
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            for (int unsigned k = 0; k < num_masters_p; k++) begin
                assert (!((wait_d[k] == wd_limit_lp) && (wait_q[k] != wd_limit_lp)))
                    else $error("watchdog: master %0d starved", k);
            end
        end
    end

    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_q)) else $error("yumi_i asserted while v_o low");
            assert ($onehot0(yumi_o)) else $error("yumi_o not one-hot0");
            assert ((yumi_o & ~v_i) == '0) else $error("yumi_o to a non-valid master");
        end
    end

endmodule
